// File: rtl/chasis_pkg.sv
// Shared types and constants for the chasis clock/reset front end.
package chasis_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PEND = 2'd1,
    STEP = 2'd2
  } sel_state_t;

  localparam logic [23:0] DIV_8M333 = 24'd6;
  localparam logic [23:0] DIV_1K    = 24'd50000;
  localparam logic [23:0] DIV_8HZ   = 24'd6250000;

  function automatic int sel_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/chasis_clk_ctrl_btn_debounce.sv
// Pushbutton conditioner: 2-FF synchroniser, stability-window debounce and a
// one-cycle pulse on the debounced 0->1 transition.
module btn_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_raw,
  output logic o_state,
  output logic o_press
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          state_q, state_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Stability counter: any cycle where the synced input agrees clears it.
  always_comb begin
    state_d = state_q;
    cnt_d   = {CW{1'b0}};
    if (sync2_q != state_q) begin
      if (cnt_q == CW'(DB_CYCLES - 1)) begin
        state_d = ~state_q;
        cnt_d   = {CW{1'b0}};
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = {CW{1'b0}};
    end
    press_d = state_d & ~state_q;
  end

  // Synchroniser and debounce state registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= {CW{1'b0}};
    end else begin
      sync1_q <= i_raw;
      sync2_q <= sync1_q;
      state_q <= state_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_state = state_q;
  assign o_press = press_q;

endmodule

// File: rtl/chasis_clk_ctrl.sv
// Board-side clock-enable generator with selectable divide ratio, single-step
// mode, debounced buttons and a stretched, synchronously released DUT reset.
module chasis_clk_ctrl
  import chasis_pkg::*;
#(
  parameter int                          NUM_RATES   = 4,
  parameter int                          DIV_W       = 24,
  parameter logic [NUM_RATES*DIV_W-1:0]  RATE_DIVS   = {DIV_8HZ, DIV_1K, DIV_8M333, 24'd1},
  parameter int                          RESET_SEL   = 2,
  parameter int                          DB_CYCLES   = 500000,
  parameter int                          RST_STRETCH = 16
) (
  input  logic                               i_clk,
  input  logic                               i_rstn,
  input  logic                               i_rateBtn,
  input  logic                               i_stepBtn,
  input  logic                               i_rstBtn,
  output logic                               o_clkEn,
  output logic [sel_width(NUM_RATES)-1:0]    o_rateSel,
  output logic                               o_isStep,
  output logic                               o_rstn,
  output logic                               o_heartbeat
);

  localparam int             SW       = sel_width(NUM_RATES);
  localparam int             STW      = $clog2(RST_STRETCH + 1);
  localparam logic [SW-1:0]  STEP_SEL = SW'(NUM_RATES);
  localparam logic [SW-1:0]  RST_SEL  = SW'(RESET_SEL);
  localparam sel_state_t     RST_ST   = (RESET_SEL == NUM_RATES) ? STEP : RUN;

  logic rate_press_s, step_press_s, rst_req_s;
  logic rate_state_s, step_state_s, rst_press_s;
  logic unused_s;

  sel_state_t       state_q, state_d;
  logic [SW-1:0]    sel_q, sel_d, pend_q, pend_d, pend_nx_s;
  logic [DIV_W-1:0] cnt_q, cnt_d, div_s, div_eff_s;
  logic             term_s;
  logic             en_q, en_d, hb_q, hb_d, rstn_q, rstn_d;
  logic [STW-1:0]   str_q, str_d;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_rate_db (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_raw(i_rateBtn), .o_state(rate_state_s), .o_press(rate_press_s));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_step_db (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_raw(i_stepBtn), .o_state(step_state_s), .o_press(step_press_s));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_rst_db (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_raw(i_rstBtn), .o_state(rst_req_s), .o_press(rst_press_s));

  assign unused_s = &{1'b0, rate_state_s, step_state_s, rst_press_s};

  function automatic logic [SW-1:0] next_sel(input logic [SW-1:0] x);
    return (x == STEP_SEL) ? {SW{1'b0}} : x + SW'(1);
  endfunction

  // Divisor lookup; a zero entry behaves as divide-by-one.
  always_comb begin
    if (sel_q < STEP_SEL) begin
      div_s = RATE_DIVS[int'(sel_q)*DIV_W +: DIV_W];
    end else begin
      div_s = {DIV_W{1'b0}};
    end
    div_eff_s = (div_s == {DIV_W{1'b0}}) ? DIV_W'(1) : div_s;
    term_s    = (cnt_q == div_eff_s - DIV_W'(1));
    pend_nx_s = rate_press_s ? next_sel(pend_q) : pend_q;
  end

  // Selector FSM and divider; switches only land on a terminal cycle so the
  // in-flight period always completes at the old rate.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    pend_d  = pend_q;
    cnt_d   = term_s ? {DIV_W{1'b0}} : cnt_q + DIV_W'(1);
    en_d    = term_s;
    case (state_q)
      RUN: begin
        if (rate_press_s) begin
          state_d = PEND;
          pend_d  = next_sel(sel_q);
        end else begin
          state_d = RUN;
        end
      end
      PEND: begin
        if (term_s) begin
          sel_d   = pend_nx_s;
          pend_d  = {SW{1'b0}};
          state_d = (pend_nx_s == STEP_SEL) ? STEP : RUN;
        end else begin
          pend_d  = pend_nx_s;
        end
      end
      STEP: begin
        cnt_d = {DIV_W{1'b0}};
        en_d  = step_press_s;
        if (rate_press_s) begin
          sel_d   = {SW{1'b0}};
          state_d = RUN;
        end else begin
          state_d = STEP;
        end
      end
      default: begin
        state_d = RST_ST;
        sel_d   = RST_SEL;
        pend_d  = {SW{1'b0}};
        cnt_d   = {DIV_W{1'b0}};
        en_d    = 1'b0;
      end
    endcase
    hb_d = hb_q ^ en_d;
  end

  // Reset stretcher: request holds o_rstn low, release counts RST_STRETCH cycles.
  always_comb begin
    if (rst_req_s) begin
      str_d  = {STW{1'b0}};
      rstn_d = 1'b0;
    end else if (!rstn_q) begin
      if (str_q == STW'(RST_STRETCH - 1)) begin
        str_d  = {STW{1'b0}};
        rstn_d = 1'b1;
      end else begin
        str_d  = str_q + STW'(1);
        rstn_d = 1'b0;
      end
    end else begin
      str_d  = str_q;
      rstn_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= RST_ST;
      sel_q   <= RST_SEL;
      pend_q  <= {SW{1'b0}};
      cnt_q   <= {DIV_W{1'b0}};
      en_q    <= 1'b0;
      hb_q    <= 1'b0;
      rstn_q  <= 1'b0;
      str_q   <= {STW{1'b0}};
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      hb_q    <= hb_d;
      rstn_q  <= rstn_d;
      str_q   <= str_d;
    end
  end

  assign o_clkEn     = en_q;
  assign o_rateSel   = sel_q;
  assign o_isStep    = (state_q == STEP);
  assign o_rstn      = rstn_q;
  assign o_heartbeat = hb_q;

endmodule

// File: tb/tb_chasis_clk_ctrl.sv
// Directed bench for chasis_clk_ctrl with a short debounce window and small divisors.
module tb_chasis_clk_ctrl;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rate_btn = 1'b0, step_btn = 1'b0, rst_btn = 1'b0;
  logic       en, is_step, dut_rstn, hb;
  logic [2:0] sel;

  int n_checks = 0, n_fail = 0;
  int cyc = 0, npress = 0, press_cyc = 0, nen = 0, en_cyc = 0;

  chasis_clk_ctrl #(
    .NUM_RATES(4), .DIV_W(24),
    .RATE_DIVS({24'd1, 24'd20, 24'd0, 24'd3}),
    .RESET_SEL(2), .DB_CYCLES(4), .RST_STRETCH(16)
  ) dut (
    .i_clk(clk), .i_rstn(rstn), .i_rateBtn(rate_btn), .i_stepBtn(step_btn),
    .i_rstBtn(rst_btn), .o_clkEn(en), .o_rateSel(sel), .o_isStep(is_step),
    .o_rstn(dut_rstn), .o_heartbeat(hb)
  );

  always #5 clk = ~clk;

  // Edge bookkeeping: cycle index plus where the rate press and enable pulses landed.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dut.u_rate_db.o_press) begin
      npress    <= npress + 1;
      press_cyc <= cyc;
    end
    if (en) begin
      nen    <= nen + 1;
      en_cyc <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_en(input int budget, output int n);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!en && n < budget);
    if (!en) check("en_timeout", {31'd0, en}, 32'd1);
  endtask

  task automatic pulse_btn(input int which, input int hold);
    if (which == 0) rate_btn = 1'b1; else step_btn = 1'b1;
    tick(hold);
    rate_btn = 1'b0;
    step_btn = 1'b0;
    tick(8);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0, m, m2, m3, m4, n, k, rst_rise, first_en, c, h0, n0, highs, ens, bad;

    tick(3);
    check("rst_clken", {31'd0, en}, 32'd0);
    check("rst_sel", {29'd0, sel}, 32'd2);
    check("rst_isstep", {31'd0, is_step}, 32'd0);
    check("rst_rstn", {31'd0, dut_rstn}, 32'd0);
    check("rst_hb", {31'd0, hb}, 32'd0);

    rstn = 1'b1;
    r0 = cyc;
    rst_rise = 0;
    first_en = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (dut_rstn && rst_rise == 0) rst_rise = i;
      if (en && first_en == 0) first_en = i;
    end
    check("rstn_release", rst_rise, 16);
    check("first_clken", first_en, 20);
    wait_en(40, n);
    check("period_sel2", n, 20);

    repeat (3) begin
      rate_btn = 1'b1; tick(2);
      rate_btn = 1'b0; tick(2);
    end
    tick(8);
    check("glitch_nopress", npress, 0);

    m = cyc;
    rate_btn = 1'b1;
    tick(10);
    rate_btn = 1'b0;
    check("press_count", npress, 1);
    check("press_latency", press_cyc - m, 6);
    check("pend_sel_held", {29'd0, sel}, 32'd2);
    wait_en(20, n);
    check("old_rate_pulse", (cyc - r0) % 20, 0);
    check("apply_sel3", {29'd0, sel}, 32'd3);
    c = 0;
    repeat (5) begin
      tick(1);
      if (en) c++;
    end
    check("d1_every_cycle", c, 5);
    tick(8);

    pulse_btn(0, 8);
    check("step_sel", {29'd0, sel}, 32'd4);
    check("step_isstep", {31'd0, is_step}, 32'd1);
    tick(3);
    check("step_idle", {31'd0, en}, 32'd0);
    h0 = hb;
    n0 = nen;
    m = cyc;
    step_btn = 1'b1;
    tick(8);
    check("step_latency", en_cyc - m, 7);
    step_btn = 1'b0;
    tick(8);
    pulse_btn(1, 8);
    pulse_btn(1, 8);
    check("step_pulses", nen - n0, 3);
    check("step_hb", {31'd0, hb}, {31'd0, ~h0[0]});

    m = cyc;
    rate_btn = 1'b1;
    tick(7);
    check("step_exit_sel", {29'd0, sel}, 32'd0);
    check("step_exit_isstep", {31'd0, is_step}, 32'd0);
    tick(1);
    rate_btn = 1'b0;
    tick(8);
    wait_en(10, n);
    wait_en(10, n);
    check("period_sel0", n, 3);

    pulse_btn(0, 8);
    check("sel1", {29'd0, sel}, 32'd1);
    c = 0;
    repeat (6) begin
      tick(1);
      if (en) c++;
    end
    check("d0_as_d1", c, 6);

    rst_btn = 1'b1;
    tick(6);
    highs = 0;
    ens = 0;
    repeat (94) begin
      tick(1);
      if (dut_rstn) highs++;
      if (en) ens++;
    end
    check("rstbtn_low", highs, 0);
    check("rstbtn_clken_runs", ens, 94);
    rst_btn = 1'b0;
    m2 = cyc;
    tick(10);
    check("stretch_low", {31'd0, dut_rstn}, 32'd0);
    m3 = cyc;
    rst_btn = 1'b1;
    tick(8);
    rst_btn = 1'b0;
    m4 = cyc;
    k = 0;
    do begin
      tick(1);
      k++;
    end while (!dut_rstn && k < 60);
    check("stretch_restart", k, 22);
    if (m3 - m2 != 10) check("stretch_timing", m3 - m2, 10);

    pulse_btn(0, 8);
    check("sel2_again", {29'd0, sel}, 32'd2);
    wait_en(30, n);
    rate_btn = 1'b1;
    tick(8);
    check("pend_before_rst", {29'd0, sel}, 32'd2);
    rstn = 1'b0;
    rate_btn = 1'b0;
    #1;
    check("async_rstn", {31'd0, dut_rstn}, 32'd0);
    check("async_clken", {31'd0, en}, 32'd0);
    check("async_sel", {29'd0, sel}, 32'd2);
    tick(3);
    rstn = 1'b1;
    first_en = 0;
    bad = 0;
    for (int i = 1; i <= 30; i++) begin
      tick(1);
      if (en && first_en == 0) first_en = i;
      if (sel != 3'd2) bad++;
    end
    check("pend_discarded", bad, 0);
    check("post_rst_first_en", first_en, 20);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
